nv_ram_rws_gen: RTL and testbench

Parametrised single-clock 1-read/1-write RAM model, the generalised successor of the fixed-size `nv_ram_rws_*` FPGA RAM models. It replaces those models wherever a buffer needs configurable width/depth, masked writes, a true registered read port with a valid strobe, and guaranteed zeroed contents after reset. It sits under NVDLA buffer/FIFO wrappers, and its port names follow the existing RAM model set.

---
 rtl/nv_ram_rws_gen_if.sv | 28 ++
 rtl/nv_ram_rws_gen.sv | 117 +++++++++++
 tb/tb_nv_ram_rws_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nv_ram_rws_gen_if.sv
// nv_ram_rws_gen_if: read/write port bundle for the generic 1R1W RAM model.
// master drives addresses/data, slave returns read data and status.
interface nv_ram_rws_gen_if #(
  parameter int DW = 16,
  parameter int AW = 5,
  parameter int MW = 2
);
  logic [AW-1:0] ra;
  logic          re;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW-1:0] wa;
  logic          we;
  logic [MW-1:0] wmask;
  logic [DW-1:0] di;
  logic          init_busy;
  logic [31:0]   pwrbus_ram_pd;

  modport master (
    output ra, re, wa, we, wmask, di, pwrbus_ram_pd,
    input  dout, dout_vld, init_busy
  );

  modport slave (
    input  ra, re, wa, we, wmask, di, pwrbus_ram_pd,
    output dout, dout_vld, init_busy
  );
endinterface

// File: rtl/nv_ram_rws_gen.sv
// nv_ram_rws_gen: parametrised 1R1W RAM, registered read, masked write,
// zero-clear sweep after reset. Macro NV_RAM_RWS_GEN_BYPASS_EN = write-first.
module nv_ram_rws_gen #(
  parameter int DW    = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 32,
  parameter int MW    = 2
) (
  input logic             clk,
  input logic             rst,
  nv_ram_rws_gen_if.slave bus
);
  localparam int LW = DW / MW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEP  = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_e;

  state_e        state_q;
  logic [IW-1:0] cnt_q;
  logic          busy_q;
  logic [DW-1:0] dout_q;
  logic          vld_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          ra_ok;
  logic          wa_ok;
  logic          wr_en;
  logic [IW-1:0] ra_idx;
  logic [IW-1:0] wa_idx;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] old_word;
  logic [DW-1:0] wr_word;
  logic [DW-1:0] dout_d;
  logic          unused_pwr;

  assign ra_ok  = {1'b0, bus.ra} < DEP;
  assign wa_ok  = {1'b0, bus.wa} < DEP;
  assign ra_idx = bus.ra[IW-1:0];
  assign wa_idx = bus.wa[IW-1:0];
  assign wr_en  = (state_q == READY) && bus.we && wa_ok;

  assign rd_word  = ra_ok ? mem_q[ra_idx] : '0;
  assign old_word = mem_q[wa_idx];

  assign unused_pwr = ^bus.pwrbus_ram_pd;

  // Lane merge of incoming data over the currently stored word.
  always_comb begin
    wr_word = old_word;
    for (int i = 0; i < MW; i++) begin
      if (bus.wmask[i]) begin
        wr_word[i*LW +: LW] = bus.di[i*LW +: LW];
      end
    end
  end

`ifdef NV_RAM_RWS_GEN_BYPASS_EN
  logic hit;
  assign hit = bus.re && wr_en && (bus.ra == bus.wa);

  // Write-first: a colliding read sees the merged word.
  always_comb begin
    dout_d = rd_word;
    if (hit) begin
      dout_d = wr_word;
    end
  end
`else
  // Read-first: a colliding read sees the pre-write word.
  always_comb begin
    dout_d = rd_word;
  end
`endif

  // Sequencer: clear sweep, then serve reads with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          vld_q <= 1'b0;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          vld_q <= bus.re;
          if (bus.re) begin
            dout_q <= dout_d;
          end
        end
      endcase
    end
  end

  // Array port: zero sweep while initialising, masked write when ready.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[wa_idx] <= wr_word;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.init_busy = busy_q;
endmodule

// File: tb/tb_nv_ram_rws_gen.sv
// tb_nv_ram_rws_gen: two DUTs (DEPTH 32 and 20) on shared stimulus,
// checked every cycle against a behavioural model plus literal checks.
module tb_nv_ram_rws_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ra = '0;
  logic [4:0]  wa = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  wmask = '0;
  logic [15:0] di = '0;
  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

`ifdef NV_RAM_RWS_GEN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  nv_ram_rws_gen_if #(.DW(16), .AW(5), .MW(2)) if0 ();
  nv_ram_rws_gen_if #(.DW(16), .AW(5), .MW(2)) if1 ();

  assign if0.ra = ra;
  assign if0.re = re;
  assign if0.wa = wa;
  assign if0.we = we;
  assign if0.wmask = wmask;
  assign if0.di = di;
  assign if0.pwrbus_ram_pd = 32'h0;
  assign if1.ra = ra;
  assign if1.re = re;
  assign if1.wa = wa;
  assign if1.we = we;
  assign if1.wmask = wmask;
  assign if1.di = di;
  assign if1.pwrbus_ram_pd = 32'hA5A5_0000;

  nv_ram_rws_gen #(.DW(16), .AW(5), .DEPTH(32), .MW(2)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  nv_ram_rws_gen #(.DW(16), .AW(5), .DEPTH(20), .MW(2)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  always #5 clk = ~clk;

  logic [15:0] dq [2];
  logic        vq [2];
  logic        bq [2];
  assign dq[0] = if0.dout;
  assign dq[1] = if1.dout;
  assign vq[0] = if0.dout_vld;
  assign vq[1] = if1.dout_vld;
  assign bq[0] = if0.init_busy;
  assign bq[1] = if1.init_busy;

  function automatic int dep(input int k);
    return (k == 0) ? 32 : 20;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o,
                                        input logic [15:0] d,
                                        input logic [1:0] m);
    logic [15:0] r;
    r = o;
    if (m[0]) r[7:0] = d[7:0];
    if (m[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Behavioural model: contents, read register, edges since reset release.
  logic [15:0] mm [2][32];
  logic [15:0] mdout [2];
  logic        mvld [2];
  int          since [2];

  always @(posedge clk or posedge rst) begin
    int d;
    logic [15:0] nxt;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        since[k] = 0;
        mdout[k] = '0;
        mvld[k] = 1'b0;
        for (int a = 0; a < 32; a++) mm[k][a] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        d = dep(k);
        if (since[k] < d) begin
          since[k]++;
          mvld[k] = 1'b0;
        end else begin
          if (re) begin
            nxt = '0;
            if (int'(ra) < d) begin
              nxt = mm[k][ra];
              if (BYP && we && wa == ra) nxt = merge(mm[k][wa], di, wmask);
            end
            mdout[k] = nxt;
            mvld[k] = 1'b1;
          end else begin
            mvld[k] = 1'b0;
          end
          if (we && int'(wa) < d) mm[k][wa] = merge(mm[k][wa], di, wmask);
        end
      end
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, k, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("m_busy", k, {15'b0, bq[k]}, {15'b0, since[k] < dep(k)});
        chk("m_vld", k, {15'b0, vq[k]}, {15'b0, mvld[k]});
        chk("m_dout", k, dq[k], mdout[k]);
      end
    end
  end

  task automatic op(input logic r, input logic [4:0] a_r,
                    input logic w, input logic [4:0] a_w,
                    input logic [1:0] m, input logic [15:0] d);
    re = r;
    ra = a_r;
    we = w;
    wa = a_w;
    wmask = m;
    di = d;
    @(negedge clk);
  endtask

  task automatic idle();
    op(1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 16'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    op(1'b0, 5'd0, 1'b1, a, 2'b11, d);
  endtask

  task automatic rd(input logic [4:0] a);
    op(1'b1, a, 1'b0, 5'd0, 2'b00, 16'h0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, {15'b0, bq[k]}, 16'h1);
      chk("rst_vld", k, {15'b0, vq[k]}, 16'h0);
      chk("rst_dout", k, dq[k], 16'h0);
    end
    #1 rst = 1'b0;

    // INIT sweep with accesses that must be ignored
    for (int e = 1; e <= 32; e++) begin
      if (e <= 20) op(1'b1, 5'd5, 1'b1, 5'd5, 2'b11, 16'hFFFF);
      else idle();
      chk("init_busy", 0, {15'b0, bq[0]}, {15'b0, e < 32});
      chk("init_busy", 1, {15'b0, bq[1]}, {15'b0, e < 20});
      chk("init_vld", 0, {15'b0, vq[0]}, 16'h0);
    end

    for (int i = 0; i < 32; i++) begin
      rd(5'(i));
      for (int k = 0; k < 2; k++) begin
        chk("clr_dout", k, dq[k], 16'h0);
        chk("clr_vld", k, {15'b0, vq[k]}, 16'h1);
      end
    end
    idle();

    // Masked writes
    wr(5'd5, 16'hABCD);
    op(1'b0, 5'd0, 1'b1, 5'd5, 2'b01, 16'h1234);
    op(1'b0, 5'd0, 1'b1, 5'd5, 2'b00, 16'h0000);
    rd(5'd5);
    for (int k = 0; k < 2; k++) chk("mask_dout", k, dq[k], 16'hAB34);
    idle();
    for (int k = 0; k < 2; k++) chk("mask_pulse", k, {15'b0, vq[k]}, 16'h0);

    // Collision
    wr(5'd7, 16'h0001);
    op(1'b1, 5'd7, 1'b1, 5'd7, 2'b11, 16'h00FF);
    for (int k = 0; k < 2; k++)
      chk("coll_dout", k, dq[k], BYP ? 16'h00FF : 16'h0001);
    rd(5'd7);
    for (int k = 0; k < 2; k++) chk("coll_after", k, dq[k], 16'h00FF);

    // Hold after read
    wr(5'd3, 16'h5555);
    rd(5'd3);
    op(1'b0, 5'd0, 1'b1, 5'd3, 2'b11, 16'hAAAA);
    for (int k = 0; k < 2; k++) begin
      chk("hold_dout", k, dq[k], 16'h5555);
      chk("hold_vld", k, {15'b0, vq[k]}, 16'h0);
    end
    rd(5'd3);
    for (int k = 0; k < 2; k++) chk("hold_new", k, dq[k], 16'hAAAA);

    // Range: address 25 is beyond DEPTH only for dut1
    wr(5'd25, 16'hFFFF);
    rd(5'd25);
    chk("rng_dout", 1, dq[1], 16'h0);
    chk("rng_vld", 1, {15'b0, vq[1]}, 16'h1);
    chk("rng_in", 0, dq[0], 16'hFFFF);
    rd(5'd5);
    for (int k = 0; k < 2; k++) chk("rng_a5", k, dq[k], 16'hAB34);

    // Reset mid-run, then reset again in the middle of INIT
    for (int i = 0; i < 32; i++) wr(5'(i), 16'h1001 + 16'(i));
    rd(5'd31);
    chk("fill", 0, dq[0], 16'h1020);
    pulse_rst();
    for (int e = 1; e <= 9; e++) idle();
    chk("mid_busy", 0, {15'b0, bq[0]}, 16'h1);
    pulse_rst();
    for (int e = 1; e <= 32; e++) begin
      idle();
      chk("rinit_busy", 0, {15'b0, bq[0]}, {15'b0, e < 32});
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i));
      for (int k = 0; k < 2; k++) chk("rclr_dout", k, dq[k], 16'h0);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
